cdb_arbiter: RTL and testbench

- Common data bus arbiter between the functional units and the ROB broadcast input.
- Each FU completion (rob index, value, nzcv, mispred) lands in a small per-FU queue.
- A round-robin arbiter picks one queued result per cycle into a registered output stage, which drives the single ROB write/broadcast port with a valid/ready handshake.
- Back-pressures the FUs when their queue is full; drops everything on flush.

---
 rtl/cdb_arbiter_pkg.sv | 25 ++
 rtl/cdb_src_fifo.sv | 69 ++++++
 rtl/cdb_arbiter.sv | 125 ++++++++++++
 tb/tb_cdb_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared types and sizes for the common data bus arbiter.
//   nzcv_t      : condition flags carried with a result
//   cdb_entry_t : one queued/broadcast FU completion
package cdb_arbiter_pkg;

   localparam int unsigned ROB_IDX_SIZE = 6;
   localparam int unsigned GPR_SIZE     = 64;
   localparam int unsigned CDB_NUM_SRC  = 4;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } nzcv_t;

   typedef struct packed {
      logic [ROB_IDX_SIZE-1:0] rob_idx;
      logic [GPR_SIZE-1:0]     value;
      logic                    set_nzcv;
      nzcv_t                   nzcv;
      logic                    is_mispred;
   } cdb_entry_t;

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-FU completion queue (power-of-2 depth, simultaneous push/pop allowed).
//   in_clk/in_rst : clock, async active-high reset
//   flush         : empties the queue; same-cycle push/pop ignored
//   push/din      : enqueue request and payload (ignored when full)
//   pop           : dequeue request (ignored when empty)
//   full/empty    : occupancy flags from registered count
//   head          : oldest entry
module cdb_src_fifo
   import cdb_arbiter_pkg::*;
#(
   parameter int unsigned QDEPTH = 2
) (
   input  logic       in_clk,
   input  logic       in_rst,
   input  logic       flush,
   input  logic       push,
   input  cdb_entry_t din,
   input  logic       pop,
   output logic       full,
   output logic       empty,
   output cdb_entry_t head
);

   localparam int unsigned PTR_W = $clog2(QDEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   cdb_entry_t       mem [QDEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(QDEPTH));
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;

   // Storage, pointers and occupancy; pointers wrap naturally at QDEPTH.
   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int unsigned i = 0; i < QDEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (do_push && !do_pop) begin
            count <= count + CNT_W'(1);
         end else if (do_pop && !do_push) begin
            count <= count - CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-FU completion queues feeding a round-robin
// picker and a registered single-port ROB broadcast stage (valid/ready).
//   in_clk, in_rst        : clock, async active-high reset
//   in_flush              : drops all queued and staged results
//   in_fu_*               : per-FU completion (flattened NUM_SRC lanes)
//   out_fu_ready          : per-FU queue not full
//   in_rob_ready          : ROB accepts the staged broadcast
//   out_rob_*             : staged broadcast payload and valid
//   out_src_id            : FU that produced the staged result
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int unsigned NUM_SRC = CDB_NUM_SRC,
   parameter int unsigned QDEPTH  = 2,
   localparam int unsigned SRC_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic                            in_clk,
   input  logic                            in_rst,
   input  logic                            in_flush,
   input  logic [NUM_SRC-1:0]              in_fu_done,
   input  logic [NUM_SRC*ROB_IDX_SIZE-1:0] in_fu_dst_rob_index,
   input  logic [NUM_SRC*GPR_SIZE-1:0]     in_fu_value,
   input  logic [NUM_SRC-1:0]              in_fu_set_nzcv,
   input  logic [NUM_SRC*4-1:0]            in_fu_nzcv,
   input  logic [NUM_SRC-1:0]              in_fu_is_mispred,
   output logic [NUM_SRC-1:0]              out_fu_ready,
   input  logic                            in_rob_ready,
   output logic                            out_rob_done,
   output logic [ROB_IDX_SIZE-1:0]         out_rob_dst_rob_index,
   output logic [GPR_SIZE-1:0]             out_rob_value,
   output logic                            out_rob_set_nzcv,
   output logic [3:0]                      out_rob_nzcv,
   output logic                            out_rob_is_mispred,
   output logic [SRC_W-1:0]                out_src_id
);

   cdb_entry_t         fu_entry [NUM_SRC];
   cdb_entry_t         head     [NUM_SRC];
   cdb_entry_t         grant_entry;
   logic [NUM_SRC-1:0] full;
   logic [NUM_SRC-1:0] empty;
   logic [NUM_SRC-1:0] push;
   logic [NUM_SRC-1:0] pop;
   logic [SRC_W-1:0]   rr_ptr;
   logic [SRC_W-1:0]   winner;
   logic [SRC_W-1:0]   rr_next;
   logic               grant_valid;
   logic               load;

   assign out_fu_ready = ~full;
   assign load         = !out_rob_done || in_rob_ready;

   // Per-source payload unpacking and queue instances.
   for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
      assign fu_entry[g] = '{
         rob_idx:    in_fu_dst_rob_index[g*ROB_IDX_SIZE +: ROB_IDX_SIZE],
         value:      in_fu_value[g*GPR_SIZE +: GPR_SIZE],
         set_nzcv:   in_fu_set_nzcv[g],
         nzcv:       nzcv_t'(in_fu_nzcv[g*4 +: 4]),
         is_mispred: in_fu_is_mispred[g]
      };
      assign push[g] = in_fu_done[g] && !full[g] && !in_flush;
      assign pop[g]  = load && grant_valid && !in_flush && (winner == SRC_W'(g));

      cdb_src_fifo #(.QDEPTH(QDEPTH)) u_fifo (
         .in_clk (in_clk),
         .in_rst (in_rst),
         .flush  (in_flush),
         .push   (push[g]),
         .din    (fu_entry[g]),
         .pop    (pop[g]),
         .full   (full[g]),
         .empty  (empty[g]),
         .head   (head[g])
      );
   end

   // Round-robin pick: first non-empty queue at or after rr_ptr, with wrap.
   always_comb begin
      int unsigned cand;
      grant_valid = 1'b0;
      winner      = '0;
      cand        = 0;
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
         cand = (32'(rr_ptr) + k) % NUM_SRC;
         if (!grant_valid && !empty[SRC_W'(cand)]) begin
            grant_valid = 1'b1;
            winner      = SRC_W'(cand);
         end
      end
      grant_entry = head[winner];
      rr_next     = (winner == SRC_W'(NUM_SRC - 1)) ? '0 : winner + SRC_W'(1);
   end

   // Broadcast stage; payload only changes on a grant so it holds under stall.
   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         out_rob_done          <= 1'b0;
         out_rob_dst_rob_index <= '0;
         out_rob_value         <= '0;
         out_rob_set_nzcv      <= 1'b0;
         out_rob_nzcv          <= '0;
         out_rob_is_mispred    <= 1'b0;
         out_src_id            <= '0;
         rr_ptr                <= '0;
      end else if (in_flush) begin
         out_rob_done <= 1'b0;
         rr_ptr       <= '0;
      end else if (load) begin
         if (grant_valid) begin
            out_rob_done          <= 1'b1;
            out_rob_dst_rob_index <= grant_entry.rob_idx;
            out_rob_value         <= grant_entry.value;
            out_rob_set_nzcv      <= grant_entry.set_nzcv;
            out_rob_nzcv          <= grant_entry.nzcv;
            out_rob_is_mispred    <= grant_entry.is_mispred;
            out_src_id            <= winner;
            rr_ptr                <= rr_next;
         end else begin
            out_rob_done <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: scenario tasks with inline checks and
// an expected-broadcast queue consumed whenever a transfer completes.
module tb_cdb_arbiter;
   import cdb_arbiter_pkg::*;

   localparam int unsigned NS = 4;
   localparam int unsigned RW = ROB_IDX_SIZE;
   localparam int unsigned GW = GPR_SIZE;

   typedef struct {
      cdb_entry_t  e;
      logic [1:0]  src;
   } exp_t;

   logic             clk;
   logic             in_rst;
   logic             in_flush;
   logic [NS-1:0]    in_fu_done;
   logic [NS*RW-1:0] in_fu_dst_rob_index;
   logic [NS*GW-1:0] in_fu_value;
   logic [NS-1:0]    in_fu_set_nzcv;
   logic [NS*4-1:0]  in_fu_nzcv;
   logic [NS-1:0]    in_fu_is_mispred;
   logic [NS-1:0]    out_fu_ready;
   logic             in_rob_ready;
   logic             out_rob_done;
   logic [RW-1:0]    out_rob_dst_rob_index;
   logic [GW-1:0]    out_rob_value;
   logic             out_rob_set_nzcv;
   logic [3:0]       out_rob_nzcv;
   logic             out_rob_is_mispred;
   logic [1:0]       out_src_id;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   cdb_arbiter #(.NUM_SRC(NS), .QDEPTH(2)) dut (
      .in_clk                (clk),
      .in_rst                (in_rst),
      .in_flush              (in_flush),
      .in_fu_done            (in_fu_done),
      .in_fu_dst_rob_index   (in_fu_dst_rob_index),
      .in_fu_value           (in_fu_value),
      .in_fu_set_nzcv        (in_fu_set_nzcv),
      .in_fu_nzcv            (in_fu_nzcv),
      .in_fu_is_mispred      (in_fu_is_mispred),
      .out_fu_ready          (out_fu_ready),
      .in_rob_ready          (in_rob_ready),
      .out_rob_done          (out_rob_done),
      .out_rob_dst_rob_index (out_rob_dst_rob_index),
      .out_rob_value         (out_rob_value),
      .out_rob_set_nzcv      (out_rob_set_nzcv),
      .out_rob_nzcv          (out_rob_nzcv),
      .out_rob_is_mispred    (out_rob_is_mispred),
      .out_src_id            (out_src_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one FU completion; optionally record it as an expected broadcast.
   task automatic drive_fu(input int src, input int idx, input logic [63:0] val,
                           input logic sn, input logic [3:0] nz, input logic mp,
                           input bit expect_it);
      exp_t x;
      in_fu_done[src]                = 1'b1;
      in_fu_dst_rob_index[src*RW +: RW] = RW'(idx);
      in_fu_value[src*GW +: GW]      = val;
      in_fu_set_nzcv[src]            = sn;
      in_fu_nzcv[src*4 +: 4]         = nz;
      in_fu_is_mispred[src]          = mp;
      if (expect_it) begin
         x.e.rob_idx    = RW'(idx);
         x.e.value      = val;
         x.e.set_nzcv   = sn;
         x.e.nzcv       = nzcv_t'(nz);
         x.e.is_mispred = mp;
         x.src          = 2'(src);
         sb.push_back(x);
      end
   endtask

   task automatic clear_fu();
      in_fu_done       = '0;
      in_fu_set_nzcv   = '0;
      in_fu_is_mispred = '0;
   endtask

   // Advance one clock; a transfer visible now completes at the coming edge
   // and is matched against the oldest expected broadcast.
   task automatic cycle();
      exp_t x;
      if (!in_rst && out_rob_done && in_rob_ready) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL bcast_unexpected: got idx=%0d val=%h src=%0d, required no broadcast",
                     out_rob_dst_rob_index, out_rob_value, out_src_id);
         end else begin
            x = sb.pop_front();
            if (out_rob_dst_rob_index !== x.e.rob_idx || out_rob_value !== x.e.value ||
                out_rob_set_nzcv !== x.e.set_nzcv || out_rob_nzcv !== 4'(x.e.nzcv) ||
                out_rob_is_mispred !== x.e.is_mispred || out_src_id !== x.src) begin
               bad++;
               $display("FAIL bcast_data: got idx=%0d val=%h sn=%b nz=%b mp=%b src=%0d, required idx=%0d val=%h sn=%b nz=%b mp=%b src=%0d",
                        out_rob_dst_rob_index, out_rob_value, out_rob_set_nzcv, out_rob_nzcv,
                        out_rob_is_mispred, out_src_id, x.e.rob_idx, x.e.value, x.e.set_nzcv,
                        4'(x.e.nzcv), x.e.is_mispred, x.src);
            end
         end
      end
      if ((in_fu_done & ~out_fu_ready) != '0) begin
         total++;
         bad++;
         $display("FAIL fu_protocol: done=%b while ready=%b", in_fu_done, out_fu_ready);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      in_rst = 1'b1;
      #1;
      in_rst = 1'b0;
   endtask

   task automatic test_reset();
      @(posedge clk);
      #1;
      total++;
      if (out_rob_done !== 1'b0 || out_rob_dst_rob_index !== '0 || out_rob_value !== '0 ||
          out_rob_nzcv !== 4'b0 || out_src_id !== 2'd0) begin
         bad++;
         $display("FAIL reset_outputs: done=%b idx=%0d val=%h nz=%b src=%0d, required all 0",
                  out_rob_done, out_rob_dst_rob_index, out_rob_value, out_rob_nzcv, out_src_id);
      end
      total++;
      if (out_fu_ready !== 4'hF) begin
         bad++;
         $display("FAIL reset_ready: got %b required 1111", out_fu_ready);
      end
      in_rst = 1'b0;
   endtask

   task automatic test_single();
      drive_fu(0, 5, 64'hFFF, 1'b0, 4'b0, 1'b0, 1'b1);
      cycle();
      clear_fu();
      total++;
      if (out_rob_done !== 1'b0) begin
         bad++;
         $display("FAIL single_early: done=%b required 0 one edge after push", out_rob_done);
      end
      cycle();
      total++;
      if (out_rob_done !== 1'b1 || out_rob_dst_rob_index !== 6'd5 ||
          out_rob_value !== 64'hFFF || out_src_id !== 2'd0) begin
         bad++;
         $display("FAIL single_bcast: done=%b idx=%0d val=%h src=%0d, required 1 5 fff 0",
                  out_rob_done, out_rob_dst_rob_index, out_rob_value, out_src_id);
      end
      cycle();
      total++;
      if (out_rob_done !== 1'b0) begin
         bad++;
         $display("FAIL single_low: done=%b required 0", out_rob_done);
      end
   endtask

   task automatic test_fairness();
      do_reset();
      for (int b = 0; b < 2; b++) begin
         for (int s = 0; s < 4; s++) drive_fu(s, 1 + 4*b + s, 64'h1000 + 64'(4*b + s), 1'b0, 4'b0, 1'b0, 1'b1);
         cycle();
         clear_fu();
         for (int s = 0; s < 4; s++) begin
            cycle();
            total++;
            if (out_rob_done !== 1'b1 || out_src_id !== 2'(s) ||
                out_rob_dst_rob_index !== RW'(1 + 4*b + s)) begin
               bad++;
               $display("FAIL fair_order burst%0d slot%0d: done=%b src=%0d idx=%0d, required 1 %0d %0d",
                        b, s, out_rob_done, out_src_id, out_rob_dst_rob_index, s, 1 + 4*b + s);
            end
         end
         cycle();
         total++;
         if (out_rob_done !== 1'b0) begin
            bad++;
            $display("FAIL fair_drain burst%0d: done=%b required 0", b, out_rob_done);
         end
      end
   endtask

   task automatic test_backpressure();
      in_rob_ready = 1'b0;
      drive_fu(1, 7, 64'h107, 1'b0, 4'b0, 1'b0, 1'b1);
      cycle();
      drive_fu(1, 8, 64'h108, 1'b0, 4'b0, 1'b0, 1'b1);
      cycle();
      total++;
      if (out_fu_ready[1] !== 1'b1) begin
         bad++;
         $display("FAIL bp_ready_early: ready1=%b required 1", out_fu_ready[1]);
      end
      drive_fu(1, 9, 64'h109, 1'b0, 4'b0, 1'b0, 1'b1);
      cycle();
      clear_fu();
      total++;
      if (out_fu_ready[1] !== 1'b0) begin
         bad++;
         $display("FAIL bp_ready_full: ready1=%b required 0", out_fu_ready[1]);
      end
      for (int c = 0; c < 3; c++) begin
         total++;
         if (out_rob_done !== 1'b1 || out_rob_dst_rob_index !== 6'd7 || out_rob_value !== 64'h107) begin
            bad++;
            $display("FAIL bp_hold cyc%0d: done=%b idx=%0d val=%h, required 1 7 107",
                     c, out_rob_done, out_rob_dst_rob_index, out_rob_value);
         end
         if (c < 2) cycle();
      end
      in_rob_ready = 1'b1;
      repeat (4) cycle();
      total++;
      if (out_rob_done !== 1'b0 || out_fu_ready !== 4'hF) begin
         bad++;
         $display("FAIL bp_drain: done=%b ready=%b, required 0 1111", out_rob_done, out_fu_ready);
      end
   endtask

   task automatic test_flush();
      in_rob_ready = 1'b0;
      drive_fu(0, 10, 64'h10, 1'b0, 4'b0, 1'b0, 1'b0);
      drive_fu(1, 11, 64'h11, 1'b0, 4'b0, 1'b0, 1'b0);
      drive_fu(2, 12, 64'h12, 1'b0, 4'b0, 1'b0, 1'b0);
      cycle();
      clear_fu();
      drive_fu(0, 14, 64'h14, 1'b0, 4'b0, 1'b0, 1'b0);
      cycle();
      clear_fu();
      total++;
      if (out_rob_done !== 1'b1) begin
         bad++;
         $display("FAIL flush_pre: done=%b required 1", out_rob_done);
      end
      in_flush = 1'b1;
      drive_fu(2, 13, 64'h13, 1'b0, 4'b0, 1'b0, 1'b0);
      cycle();
      in_flush = 1'b0;
      clear_fu();
      total++;
      if (out_rob_done !== 1'b0 || out_fu_ready !== 4'hF) begin
         bad++;
         $display("FAIL flush_post: done=%b ready=%b, required 0 1111", out_rob_done, out_fu_ready);
      end
      in_rob_ready = 1'b1;
      repeat (6) cycle();
      total++;
      if (out_rob_done !== 1'b0) begin
         bad++;
         $display("FAIL flush_quiet: done=%b required 0", out_rob_done);
      end
   endtask

   task automatic test_mispred();
      drive_fu(3, 20, 64'hABCD, 1'b1, 4'b0110, 1'b1, 1'b1);
      cycle();
      clear_fu();
      cycle();
      total++;
      if (out_rob_done !== 1'b1 || out_rob_is_mispred !== 1'b1 || out_rob_set_nzcv !== 1'b1 ||
          out_rob_nzcv !== 4'b0110 || out_src_id !== 2'd3) begin
         bad++;
         $display("FAIL mispred_pass: done=%b mp=%b sn=%b nz=%b src=%0d, required 1 1 1 0110 3",
                  out_rob_done, out_rob_is_mispred, out_rob_set_nzcv, out_rob_nzcv, out_src_id);
      end
      repeat (2) cycle();
   endtask

   task automatic test_async_reset();
      in_rob_ready = 1'b0;
      drive_fu(0, 30, 64'h30, 1'b1, 4'b1111, 1'b1, 1'b0);
      cycle();
      clear_fu();
      cycle();
      total++;
      if (out_rob_done !== 1'b1) begin
         bad++;
         $display("FAIL areset_pre: done=%b required 1", out_rob_done);
      end
      #2;
      in_rst = 1'b1;
      #1;
      total++;
      if (out_rob_done !== 1'b0 || out_rob_dst_rob_index !== '0 || out_rob_value !== '0 ||
          out_rob_nzcv !== 4'b0 || out_rob_is_mispred !== 1'b0 || out_src_id !== 2'd0 ||
          out_fu_ready !== 4'hF) begin
         bad++;
         $display("FAIL areset_clear: done=%b idx=%0d val=%h nz=%b mp=%b src=%0d ready=%b, required zeros and ready 1111",
                  out_rob_done, out_rob_dst_rob_index, out_rob_value, out_rob_nzcv,
                  out_rob_is_mispred, out_src_id, out_fu_ready);
      end
      in_rst = 1'b0;
      cycle();
      in_rob_ready = 1'b1;
      drive_fu(0, 31, 64'h31, 1'b0, 4'b0, 1'b0, 1'b1);
      cycle();
      clear_fu();
      cycle();
      total++;
      if (out_rob_done !== 1'b1 || out_rob_dst_rob_index !== 6'd31 || out_src_id !== 2'd0) begin
         bad++;
         $display("FAIL areset_after: done=%b idx=%0d src=%0d, required 1 31 0",
                  out_rob_done, out_rob_dst_rob_index, out_src_id);
      end
      repeat (2) cycle();
   endtask

   initial begin
      in_rst              = 1'b1;
      in_flush            = 1'b0;
      in_rob_ready        = 1'b1;
      in_fu_dst_rob_index = '0;
      in_fu_value         = '0;
      in_fu_nzcv          = '0;
      clear_fu();
      test_reset();
      test_single();
      test_fairness();
      test_backpressure();
      test_flush();
      test_mispred();
      test_async_reset();
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL sb_leftover: %0d expected broadcasts never seen, required 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
